i2c_config_sequencer: RTL and testbench
=======================================

// Module: i2c_config_sequencer
// PURPOSE
//  Upstream feeder for i2c_master. Walks a fixed table of register writes and issues each one
//  as a 24-bit {slave_addr, sub_addr, data} word using the start/done/error handshake.
//  Retries failed writes, enforces a gap between writes, and reports completion and failure counts.
//  Runs on the same 20 kHz clk as i2c_master. Typical use is power-up configuration of a codec.
// PARAMETERS
//  SLAVE_ADDR   8'h34  8-bit write address placed in data[23:16] of every word
//  NUM_REGS     10     number of table entries (1..64)
//  MAX_RETRIES  2      extra attempts per entry after a failed attempt (0..7)
//  GAP_CYCLES   4      idle clk cycles between the end of one transaction and the next start (>=2)
//  TIMEOUT      64     clk cycles to wait for i2c_done before the attempt counts as failed
//  STARTUP_WAIT 16     cycles after reset deassertion before the first start is allowed
// PORTS
//  clk           in   1   system clock (shared with i2c_master)
//  reset         in   1   asynchronous, active-high reset
//  cfg_go        in   1   level/pulse; starts a configuration pass when the block is idle
//  i2c_start     out  1   to dstream_i2c.start; one-cycle pulse per attempt
//  i2c_data      out  24  to dstream_i2c.data; {SLAVE_ADDR, sub_addr, data}; stable from start until done
//  i2c_done      in   1   from dstream_i2c.done; high for 2 cycles at the end of each transaction
//  i2c_error     in   1   from dstream_i2c.error; sampled on the first done-high cycle (1 = NACK)
//  busy          out  1   high from the accepted cfg_go until DONE is reached
//  cfg_done      out  1   one-cycle pulse at the end of each pass
//  fail_count    out  7   number of entries skipped after exhausting retries in the last pass
// BEHAVIOUR
//  Reset values: i2c_start=0, i2c_data=0, busy=0, cfg_done=0, fail_count=0, index=0, state=WAIT_RST.
//  States:
//   - WAIT_RST: count STARTUP_WAIT cycles, then go to IDLE. This drains any transaction the
//     un-reset i2c_master had in flight.
//   - IDLE: when cfg_go=1, clear fail_count and index, set busy, go to LOAD.
//   - LOAD: i2c_data <= {SLAVE_ADDR, rom[index]}; retry counter <= 0; go to ISSUE.
//   - ISSUE: assert i2c_start for exactly 1 cycle; go to WAIT. Start must never be held, because
//     the master would re-trigger from its INIT state.
//   - WAIT: capture i2c_error on the rising edge of i2c_done (done=1 and done_q=0). Ignore the
//     second done-high cycle. If the timeout counter reaches TIMEOUT, treat the attempt as an error.
//     Then go to GAP.
//   - GAP: wait GAP_CYCLES cycles, then evaluate the attempt:
//       ok                   -> index+1
//       error, retries left  -> retry counter +1, return to ISSUE with the same data
//       error, retries spent -> fail_count+1, index+1
//     If the new index equals NUM_REGS, go to DONE; otherwise go to LOAD.
//   - DONE: pulse cfg_done for 1 cycle, clear busy, go to IDLE.
//  Boundary conditions:
//   - cfg_go while busy: ignored (no queueing). cfg_go held high in IDLE starts a new pass each
//     time IDLE is re-entered.
//   - fail_count saturates at 127.
//   - index width is $clog2(NUM_REGS+1), which gives no wrap at NUM_REGS.
//   - i2c_done seen outside WAIT: ignored.
//   - reset mid-pass: everything returns to reset values immediately and re-enters WAIT_RST.
//     No start is issued before STARTUP_WAIT has expired.
//   - Error and timeout in the same cycle: a single failure is counted.
//  Latency: from cfg_go in IDLE to the first i2c_start is 3 cycles (IDLE->LOAD->ISSUE).
// STRUCTURE
//  Package i2c_cfg_pkg:
//   - typedef struct packed {logic [7:0] sub_addr; logic [7:0] data;} cfg_entry_t
//   - seq_state_t enum
//   - default table constant CFG_TABLE[NUM_REGS]
//  Sub-module i2c_cfg_rom: combinational index -> cfg_entry_t lookup, indexed only within
//  0..NUM_REGS-1. Everything else stays in the one FSM plus its counters.
// TESTING (bench pairs the block with a behavioural i2c_master model: 24-cycle transaction, done high 2 cycles)
//  1. reset then cfg_go at cycle 20 with an ACKing model and NUM_REGS=3
//     -> 3 starts with i2c_data = 0x34_<sub>_<data> in table order; cfg_done pulses once;
//        fail_count=0; busy falls on the cfg_done cycle.
//  2. Model NACKs entry 1 once -> entry 1 issued twice, the same data repeated; fail_count=0.
//  3. Model always NACKs entry 2 with MAX_RETRIES=2 -> entry 2 issued 3 times, then skipped;
//     fail_count=1; entry 3 still sent.
//  4. Model never asserts done -> after 64 cycles the attempt counts as an error; retries follow;
//     entry skipped; no hang.
//  5. Pulse cfg_go during a busy pass -> no extra starts; exactly one cfg_done.
//  6. Assert reset during WAIT -> outputs return to 0 at once; no i2c_start for 16 cycles after
//     deassertion; a new cfg_go restarts at index 0.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// ----------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared types and the default register table for the I2C configuration
// sequencer.
//   cfg_entry_t : one table entry, {sub_addr, data}
//   seq_state_t : sequencer FSM states (also exported on the debug state port)
//   CFG_TABLE   : default codec power-up table, CFG_TABLE_LEN entries
// ----------------------------------------------------------------------------
package i2c_cfg_pkg;

   typedef struct packed {
      logic [7:0] sub_addr;
      logic [7:0] data;
   } cfg_entry_t;

   typedef enum logic [2:0] {
      WAIT_RST = 3'd0,
      IDLE     = 3'd1,
      LOAD     = 3'd2,
      ISSUE    = 3'd3,
      WAIT     = 3'd4,
      GAP      = 3'd5,
      DONE     = 3'd6
   } seq_state_t;

   localparam int CFG_TABLE_LEN = 10;

   // Codec bring-up order: reset, power, interface format, sampling,
   // input/output levels, path routing, then activate last.
   localparam cfg_entry_t CFG_TABLE [CFG_TABLE_LEN] = '{
      '{8'h1E, 8'h00},
      '{8'h0C, 8'h10},
      '{8'h0E, 8'h02},
      '{8'h10, 8'h00},
      '{8'h00, 8'h17},
      '{8'h02, 8'h17},
      '{8'h04, 8'h79},
      '{8'h06, 8'h79},
      '{8'h0A, 8'h00},
      '{8'h12, 8'h01}
   };

   localparam logic [6:0] FAIL_COUNT_MAX = 7'd127;

endpackage

// File: rtl/i2c_cfg_rom.sv
// ----------------------------------------------------------------------------
// i2c_cfg_rom
// Combinational index -> table entry lookup.
//   index_i : table index, only meaningful in 0..NUM_REGS-1
//   entry_o : {sub_addr, data}; zero for indices outside the table
// Indices beyond the default table length also read as zero, so a longer
// NUM_REGS needs CFG_TABLE extended to match.
// ----------------------------------------------------------------------------
module i2c_cfg_rom
   import i2c_cfg_pkg::*;
#(
   parameter int NUM_REGS = 10,
   parameter int IDX_W    = $clog2(NUM_REGS + 1)
) (
   input  logic [IDX_W-1:0] index_i,
   output logic [15:0]      entry_o
);

   always_comb begin
      entry_o = '0;
      for (int i = 0; (i < NUM_REGS) && (i < CFG_TABLE_LEN); i++) begin
         if (index_i == IDX_W'(i)) begin
            entry_o = CFG_TABLE[i];
         end
      end
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_config_sequencer
// Walks the register table and hands each write to i2c_master as a 24-bit
// {SLAVE_ADDR, sub_addr, data} word, with retries, an inter-write gap, a
// done timeout and a per-pass failure count.
//   clk_i        : system clock shared with i2c_master
//   reset_i      : asynchronous, active-high reset
//   cfg_go_i     : starts a pass when idle (level or pulse)
//   i2c_start_o  : one-cycle start pulse per attempt
//   i2c_data_o   : word for the master, held from start until the next entry
//   i2c_done_i   : master done, high for 2 cycles per transaction
//   i2c_error_i  : master NACK flag, valid on the first done-high cycle
//   busy_o       : high from accepted cfg_go until the pass completes
//   cfg_done_o   : one-cycle pulse at the end of each pass
//   fail_count_o : entries skipped in the last pass (saturates at 127)
//   state_o      : current FSM state (seq_state_t encoding), for debug
//
// Master handshake: a transaction is offered by a single-cycle i2c_start_o
// with i2c_data_o already valid; the master owns the transaction until it
// raises i2c_done_i. Only the rising edge of done is consumed, and only in
// WAIT; start is never held because the master re-triggers on a held start.
// ----------------------------------------------------------------------------
module i2c_config_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter logic [7:0] SLAVE_ADDR   = 8'h34,
   parameter int         NUM_REGS     = 10,
   parameter int         MAX_RETRIES  = 2,
   parameter int         GAP_CYCLES   = 4,
   parameter int         TIMEOUT      = 64,
   parameter int         STARTUP_WAIT = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cfg_go_i,
   output logic        i2c_start_o,
   output logic [23:0] i2c_data_o,
   input  logic        i2c_done_i,
   input  logic        i2c_error_i,
   output logic        busy_o,
   output logic        cfg_done_o,
   output logic [6:0]  fail_count_o,
   output logic [2:0]  state_o
);

   localparam int IDX_W   = $clog2(NUM_REGS + 1);
   localparam int CNT_A   = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CNT_MAX = (CNT_A > STARTUP_WAIT) ? CNT_A : STARTUP_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] index_q;
   logic [IDX_W-1:0] index_d;
   logic [2:0]       retry_q;
   logic             err_q;
   logic             done_q;
   logic             start_q;
   logic [23:0]      data_q;
   logic             busy_q;
   logic             cfg_done_q;
   logic [6:0]       fail_q;
   logic [15:0]      rom_entry;
   logic             done_rise;
   logic             last_entry;

   i2c_cfg_rom #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_rom (
      .index_i (index_q),
      .entry_o (rom_entry)
   );

   assign index_d    = index_q + IDX_W'(1);
   assign last_entry = (index_d == IDX_W'(NUM_REGS));
   // The second done-high cycle must not look like a new completion.
   assign done_rise  = i2c_done_i & ~done_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= WAIT_RST;
         cnt_q      <= '0;
         index_q    <= '0;
         retry_q    <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         fail_q     <= '0;
      end else begin
         start_q    <= 1'b0;
         cfg_done_q <= 1'b0;
         done_q     <= i2c_done_i;
         case (state_q)
            // Lets a master that was not reset with us finish its transaction.
            WAIT_RST: begin
               if (cnt_q == CNT_W'(STARTUP_WAIT - 1)) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            IDLE: begin
               if (cfg_go_i) begin
                  fail_q  <= '0;
                  index_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               data_q  <= {SLAVE_ADDR, rom_entry};
               retry_q <= '0;
               state_q <= ISSUE;
            end
            ISSUE: begin
               start_q <= 1'b1;
               cnt_q   <= '0;
               err_q   <= 1'b0;
               state_q <= WAIT;
            end
            // A done edge wins over a coinciding timeout, so one attempt
            // can only ever produce one verdict.
            WAIT: begin
               if (done_rise) begin
                  err_q   <= i2c_error_i;
                  cnt_q   <= '0;
                  state_q <= GAP;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= GAP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (err_q && (retry_q < 3'(MAX_RETRIES))) begin
                     retry_q <= retry_q + 3'd1;
                     state_q <= ISSUE;
                  end else begin
                     if (err_q && (fail_q != FAIL_COUNT_MAX)) begin
                        fail_q <= fail_q + 7'd1;
                     end
                     index_q <= index_d;
                     state_q <= last_entry ? DONE : LOAD;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               cfg_done_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= WAIT_RST;
            end
         endcase
      end
   end

   assign i2c_start_o  = start_q;
   assign i2c_data_o   = data_q;
   assign busy_o       = busy_q;
   assign cfg_done_o   = cfg_done_q;
   assign fail_count_o = fail_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
module tb_i2c_config_sequencer;
   import i2c_cfg_pkg::*;

   localparam int          NREGS = 3;
   localparam logic [23:0] W0    = 24'h341E00;
   localparam logic [23:0] W1    = 24'h340C10;
   localparam logic [23:0] W2    = 24'h340E02;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic cfg_go = 1'b0;
   always #5 clk = ~clk;

   logic        start, busy, cfg_done;
   logic [23:0] data;
   logic [6:0]  fail;
   logic [2:0]  state;
   logic        done, err;
   logic        m_done = 1'b0, m_err = 1'b0;
   logic        stray_done = 1'b0, stray_err = 1'b0;
   assign done = m_done | stray_done;
   assign err  = m_err | stray_err;

   i2c_config_sequencer #(
      .SLAVE_ADDR   (8'h34),
      .NUM_REGS     (NREGS),
      .MAX_RETRIES  (2),
      .GAP_CYCLES   (4),
      .TIMEOUT      (64),
      .STARTUP_WAIT (16)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .cfg_go_i     (cfg_go),
      .i2c_start_o  (start),
      .i2c_data_o   (data),
      .i2c_done_i   (done),
      .i2c_error_i  (err),
      .busy_o       (busy),
      .cfg_done_o   (cfg_done),
      .fail_count_o (fail),
      .state_o      (state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] word_of(input logic [3:0] k);
      case (k)
         4'd0:    word_of = W0;
         4'd1:    word_of = W1;
         4'd2:    word_of = W2;
         default: word_of = 24'h000000;
      endcase
   endfunction

   function automatic int idx_of(input logic [23:0] w);
      if (w == W0)      idx_of = 0;
      else if (w == W1) idx_of = 1;
      else if (w == W2) idx_of = 2;
      else              idx_of = 3;
   endfunction

   // ---------------- i2c_master model + monitor ----------------
   // modes: 0 ack all, 1 nack first attempt of tgt, 2 nack every attempt of
   // tgt, 3 tgt never raises done, 4 nack everything
   int          m_mode = 0;
   int          m_tgt  = 0;
   bit          m_busy = 1'b0;
   bit          m_nack = 1'b0;
   bit          m_mute = 1'b0;
   int          m_cnt  = 0;
   int          m_k    = 0;
   int          m_att[4];
   logic [23:0] m_data = '0;
   int          done_cnt = 0, held_cnt = 0, unstable_cnt = 0;
   bit          start_prev = 1'b0, busy_prev = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
         start_prev = 1'b0; busy_prev = 1'b0;
      end else begin
         if (start) begin
            got_q.push_back(data);
            if (start_prev) held_cnt++;
         end
         if (cfg_done) begin
            done_cnt++;
            check("busy_falls_with_cfg_done", 32'({busy_prev, busy}), 32'h2);
         end
         if (m_busy && (data !== m_data)) unstable_cnt++;
         start_prev = start;
         busy_prev  = busy;
         if (!m_busy && start) begin
            m_k = idx_of(data);
            m_att[m_k]++;
            m_busy = 1'b1; m_cnt = 0; m_data = data;
            m_nack = (m_mode == 1 && m_k == m_tgt && m_att[m_k] == 1) ||
                     (m_mode == 2 && m_k == m_tgt) || (m_mode == 4);
            m_mute = (m_mode == 3 && m_k == m_tgt);
         end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 22) begin
               m_done = !m_mute;
               m_err  = m_nack && !m_mute;
            end else if (m_cnt == 23) begin
               m_err = 1'b0;
            end else if (m_cnt == 24) begin
               m_done = 1'b0;
               m_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- vector table ----------------
   // seq: expected entry order of starts, one hex digit each, left to right
   typedef struct packed {
      logic [2:0]  mode;
      logic [1:0]  tgt;
      logic        mid_go;
      logic [3:0]  n_exp;
      logic [35:0] seq;
      logic [6:0]  exp_fail;
   } vec_t;

   vec_t vecs[6];
   vec_t cur;
   logic s1, s2, s3, b1;
   int   cyc;
   int   k;

   task automatic clear_run();
      got_q.delete();
      exp_q.delete();
      done_cnt = 0; held_cnt = 0; unstable_cnt = 0;
      foreach (m_att[i]) m_att[i] = 0;
   endtask

   initial begin
      vecs[0] = '{3'd0, 2'd0, 1'b0, 4'd3, 36'h012000000, 7'd0};
      vecs[1] = '{3'd1, 2'd0, 1'b0, 4'd4, 36'h001200000, 7'd0};
      vecs[2] = '{3'd2, 2'd1, 1'b0, 4'd5, 36'h011120000, 7'd1};
      vecs[3] = '{3'd3, 2'd2, 1'b0, 4'd5, 36'h012220000, 7'd1};
      vecs[4] = '{3'd0, 2'd0, 1'b1, 4'd3, 36'h012000000, 7'd0};
      vecs[5] = '{3'd4, 2'd0, 1'b0, 4'd9, 36'h000111222, 7'd3};

      // reset values
      repeat (3) @(negedge clk);
      check("rst_start",    32'(start),    32'h0);
      check("rst_data",     32'(data),     32'h0);
      check("rst_busy",     32'(busy),     32'h0);
      check("rst_cfg_done", 32'(cfg_done), 32'h0);
      check("rst_fail",     32'(fail),     32'h0);
      check("rst_state",    32'(state),    32'(WAIT_RST));
      reset = 1'b0;

      // startup wait is exactly 16 cycles
      repeat (15) @(negedge clk);
      check("startup_still_waiting", 32'(state), 32'(WAIT_RST));
      @(negedge clk);
      check("startup_reaches_idle", 32'(state), 32'(IDLE));

      // stray done in IDLE is ignored
      clear_run();
      repeat (2) @(negedge clk);
      stray_done = 1'b1; stray_err = 1'b1;
      repeat (2) @(negedge clk);
      stray_done = 1'b0; stray_err = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_done_state", 32'(state), 32'(IDLE));
      check("stray_done_starts", 32'(got_q.size()), 32'h0);

      // table-driven passes
      for (int v = 0; v < 6; v++) begin
         cur = vecs[v];
         clear_run();
         m_mode = int'(cur.mode);
         m_tgt  = int'(cur.tgt);
         for (int i = 0; i < int'(cur.n_exp); i++)
            exp_q.push_back(word_of(cur.seq[35 - 4*i -: 4]));

         cfg_go = 1'b1;
         @(negedge clk); cfg_go = 1'b0; s1 = start; b1 = busy;
         @(negedge clk); s2 = start;
         @(negedge clk); s3 = start;
         check($sformatf("v%0d_start_latency", v), 32'({s1, s2, s3}), 32'h1);
         check($sformatf("v%0d_busy_after_go", v), 32'(b1), 32'h1);

         cyc = 0;
         while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cur.mid_go) cfg_go = (cyc >= 40 && cyc < 45) || (cyc == 60);
         end
         cfg_go = 1'b0;
         check($sformatf("v%0d_pass_finished", v), 32'(cyc < 3000), 32'h1);
         repeat (40) @(negedge clk);

         check($sformatf("v%0d_cfg_done_pulses", v), 32'(done_cnt), 32'h1);
         check($sformatf("v%0d_start_count", v), 32'(got_q.size()), 32'(cur.n_exp));
         for (int i = 0; i < int'(cur.n_exp) && got_q.size() > 0; i++)
            check($sformatf("v%0d_start%0d_data", v, i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
         check($sformatf("v%0d_fail_count", v), 32'(fail), 32'(cur.exp_fail));
         check($sformatf("v%0d_start_held", v), 32'(held_cnt), 32'h0);
         check($sformatf("v%0d_data_stable", v), 32'(unstable_cnt), 32'h0);
         check($sformatf("v%0d_back_idle", v), 32'(state), 32'(IDLE));
      end

      // reset during WAIT
      clear_run();
      m_mode = 0;
      cfg_go = 1'b1;
      @(negedge clk); cfg_go = 1'b0;
      cyc = 0;
      while (got_q.size() == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      repeat (5) @(negedge clk);
      check("mid_state_wait", 32'(state), 32'(WAIT));
      reset = 1'b1;
      #1;
      check("mid_rst_start", 32'(start), 32'h0);
      check("mid_rst_data",  32'(data),  32'h0);
      check("mid_rst_busy",  32'(busy),  32'h0);
      check("mid_rst_state", 32'(state), 32'(WAIT_RST));
      repeat (2) @(negedge clk);
      clear_run();
      reset  = 1'b0;
      cfg_go = 1'b1;
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (start) break;
      end
      cfg_go = 1'b0;
      check("post_rst_first_start_cycle", 32'(k), 32'd19);
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("post_rst_pass_finished", 32'(cyc < 3000), 32'h1);
      repeat (10) @(negedge clk);
      exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
      check("post_rst_start_count", 32'(got_q.size()), 32'd3);
      while (got_q.size() > 0 && exp_q.size() > 0)
         check("post_rst_start_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      check("post_rst_fail_count", 32'(fail), 32'h0);
      check("post_rst_cfg_done_pulses", 32'(done_cnt), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
